// File: rtl/alu_operand_core.sv
// Operand-entry and arithmetic core: two push-button stepped operand registers,
// an eight-function ALU with registered result/NZCV flags, and accumulate-into-A.
module alu_operand_core #(
    parameter int WIDTH = 4,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       btn,
    input  logic [1:0]       dir,
    input  logic [2:0]       func,
    input  logic             acc_btn,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             upd
);

    localparam int SH_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
    localparam logic [WIDTH:0]   ONE_X  = {{WIDTH{1'b0}}, 1'b1};

    localparam logic [2:0] F_ADD = 3'b000;
    localparam logic [2:0] F_SUB = 3'b001;
    localparam logic [2:0] F_AND = 3'b010;
    localparam logic [2:0] F_OR  = 3'b011;
    localparam logic [2:0] F_XOR = 3'b100;
    localparam logic [2:0] F_NOR = 3'b101;
    localparam logic [2:0] F_SLT = 3'b110;
    localparam logic [2:0] F_SHL = 3'b111;

    // Returns {N, Z, C, V, result}.
    function automatic logic [WIDTH+3:0] alu_eval(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [2:0]       f
    );
        logic signed [WIDTH-1:0] a_s;
        logic signed [WIDTH-1:0] b_s;
        logic [WIDTH:0]          sum;
        logic [WIDTH:0]          shl;
        logic [WIDTH-1:0]        r;
        logic                    c;
        logic                    v;
        a_s = a;
        b_s = b;
        sum = '0;
        shl = '0;
        r   = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (f)
            F_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                r   = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            F_SUB: begin
                // Carry out of A + ~B + 1 is the inverted borrow.
                sum = {1'b0, a} + {1'b0, ~b} + ONE_X;
                r   = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            F_AND: r = a & b;
            F_OR:  r = a | b;
            F_XOR: r = a ^ b;
            F_NOR: r = ~(a | b);
            F_SLT: r = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            F_SHL: begin
                // Bit WIDTH of the extended shift is the last bit pushed out (0 for no shift).
                shl = {1'b0, a} << b[SH_W-1:0];
                r   = shl[WIDTH-1:0];
                c   = shl[WIDTH];
            end
            default: r = '0;
        endcase
        return {r[WIDTH-1], (r == '0), c, v, r};
    endfunction

    function automatic logic [WIDTH-1:0] step_op(
        input logic [WIDTH-1:0] val,
        input logic             down
    );
        return down ? (val - STEP_W) : (val + STEP_W);
    endfunction

    logic [1:0]       btn_q;
    logic             acc_q;
    logic [WIDTH-1:0] op_a_p0;
    logic [WIDTH-1:0] op_b_p0;
    logic             upd_p0;
    logic [WIDTH-1:0] result_p1;
    logic [3:0]       flags_p1;

    logic [1:0]       press;
    logic             acc_press;
    logic [WIDTH+3:0] alu_out;
    logic [WIDTH-1:0] next_a;
    logic [WIDTH-1:0] next_b;

    // Stage p0: edge detect and operand update.
    always_comb begin
        press     = btn & ~btn_q;
        acc_press = acc_btn & ~acc_q;
        alu_out   = alu_eval(op_a_p0, op_b_p0, func);
        next_a    = op_a_p0;
        next_b    = op_b_p0;
        if (acc_press) begin
            next_a = alu_out[WIDTH-1:0];
        end else if (press[0]) begin
            next_a = step_op(op_a_p0, dir[0]);
        end
        if (press[1]) begin
            next_b = step_op(op_b_p0, dir[1]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Ones in the edge registers swallow a press held through reset.
            btn_q     <= 2'b11;
            acc_q     <= 1'b1;
            op_a_p0   <= '0;
            op_b_p0   <= '0;
            upd_p0    <= 1'b0;
            result_p1 <= '0;
            flags_p1  <= 4'b0100;
        end else begin
            btn_q     <= btn;
            acc_q     <= acc_btn;
            op_a_p0   <= next_a;
            op_b_p0   <= next_b;
            upd_p0    <= (next_a != op_a_p0) || (next_b != op_b_p0);
            // Stage p1: result registered from the current operand registers.
            result_p1 <= alu_out[WIDTH-1:0];
            flags_p1  <= alu_out[WIDTH+3:WIDTH];
        end
    end

    assign op_a   = op_a_p0;
    assign op_b   = op_b_p0;
    assign upd    = upd_p0;
    assign result = result_p1;
    assign flags  = flags_p1;

endmodule
